// File: rtl/reg_file.sv
// rtl/reg_file.sv - integer register file with combinational bypass reads and a pending-write scoreboard
module reg_file #(
  parameter int WIDTH      = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [WIDTH-1:0]      rs1_data,
  output logic                  rs1_busy,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [WIDTH-1:0]      rs2_data,
  output logic                  rs2_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  claim_en,
  input  logic [ADDR_WIDTH-1:0] claim_addr,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   busy_count
);

  logic [WIDTH-1:0]    mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [ADDR_WIDTH:0] busy_count_q, busy_count_d;

  // A claim outranks a same-cycle retire: the new producer supersedes the old one.
  always_comb begin
    pending_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pending_d[r] = pending_q[r];
      if (flush) begin
        pending_d[r] = 1'b0;
      end else if (claim_en && (claim_addr == ADDR_WIDTH'(r))) begin
        pending_d[r] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_WIDTH'(r))) begin
        pending_d[r] = 1'b0;
      end
    end
  end

  always_comb begin
    busy_count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_count_d = busy_count_d + {{ADDR_WIDTH{1'b0}}, pending_d[r]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
      pending_q    <= '0;
      busy_count_q <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) begin
        mem_q[wr_addr] <= wr_data;
      end
      pending_q    <= pending_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Writeback data is forwarded so a reader sees it in the same cycle, already released.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (!rst && (rs1_addr != '0)) begin
      if (wr_en && (wr_addr == rs1_addr)) begin
        rs1_data = wr_data;
      end else begin
        rs1_data = mem_q[rs1_addr];
        rs1_busy = pending_q[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (!rst && (rs2_addr != '0)) begin
      if (wr_en && (wr_addr == rs2_addr)) begin
        rs2_data = wr_data;
      end else begin
        rs2_data = mem_q[rs2_addr];
        rs2_busy = pending_q[rs2_addr];
      end
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed table-driven bench for reg_file
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, claim_addr;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        rs1_busy, rs2_busy, wr_en, claim_en, flush;
  logic [5:0]  busy_count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file #(.WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data),
    .rs1_busy   (rs1_busy),
    .rs2_addr   (rs2_addr),
    .rs2_data   (rs2_data),
    .rs2_busy   (rs2_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] e_rs1_data;
    logic        e_rs1_busy;
    logic [31:0] e_rs2_data;
    logic        e_rs2_busy;
    logic [5:0]  e_bc;
  } vec_t;

  function automatic vec_t mk(int we, int wa, logic [31:0] wd, int ce, int ca, int fl,
                              int a1, int a2, logic [31:0] d1, int b1,
                              logic [31:0] d2, int b2, int bc);
    vec_t v;
    v.wr_en = 1'(we);   v.wr_addr = 5'(wa);    v.wr_data = wd;
    v.claim_en = 1'(ce); v.claim_addr = 5'(ca); v.flush = 1'(fl);
    v.rs1_addr = 5'(a1); v.rs2_addr = 5'(a2);
    v.e_rs1_data = d1;  v.e_rs1_busy = 1'(b1);
    v.e_rs2_data = d2;  v.e_rs2_busy = 1'(b2);
    v.e_bc = 6'(bc);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    //          we wa wd            ce ca fl  a1 a2  d1            b1 d2            b2 bc
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,  5, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 0,  5, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0);
    vecs[2]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0,  0, 5, 32'h0,        0, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        1, 7, 0,  7, 7, 32'h0,        0, 32'h0,        0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        0, 0, 0,  5, 7, 32'hDEADBEEF, 0, 32'h0,        1, 1);
    vecs[6]  = mk(1, 7, 32'h12,       0, 0, 0,  7, 7, 32'h12,       0, 32'h12,       0, 1);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 0,  7, 7, 32'h12,       0, 32'h12,       0, 0);
    vecs[8]  = mk(1, 3, 32'h55,       1, 3, 0,  3, 3, 32'h55,       0, 32'h55,       0, 0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 0,  3, 7, 32'h55,       1, 32'h12,       0, 1);
    vecs[10] = mk(1, 3, 32'h66,       1, 9, 0,  3, 9, 32'h66,       0, 32'h0,        0, 1);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 0,  3, 9, 32'h66,       0, 32'h0,        1, 1);
    vecs[12] = mk(1, 5, 32'hA5A5,     1, 4, 1,  9, 4, 32'h0,        1, 32'h0,        0, 1);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 0,  5, 4, 32'hA5A5,     0, 32'h0,        0, 0);
    vecs[14] = mk(0, 0, 32'h0,        1, 6, 0,  6, 6, 32'h0,        0, 32'h0,        0, 0);
    vecs[15] = mk(0, 0, 32'h0,        1, 8, 0,  6, 8, 32'h0,        1, 32'h0,        0, 1);
    vecs[16] = mk(0, 0, 32'h0,        0, 0, 0,  6, 8, 32'h0,        1, 32'h0,        1, 2);

    rst = 1'b1;
    idle();
    rs1_addr = '0; rs2_addr = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("reset rs1_data x%0d", i), rs1_data, 32'h0);
      chk($sformatf("reset rs1_busy x%0d", i), 32'(rs1_busy), 32'h0);
      chk($sformatf("reset rs2_data x%0d", 31 - i), rs2_data, 32'h0);
      chk($sformatf("reset rs2_busy x%0d", 31 - i), 32'(rs2_busy), 32'h0);
    end
    chk("reset busy_count", 32'(busy_count), 32'h0);

    for (int i = 0; i < 17; i++) begin
      next_cycle();
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      claim_en = vecs[i].claim_en; claim_addr = vecs[i].claim_addr; flush = vecs[i].flush;
      rs1_addr = vecs[i].rs1_addr; rs2_addr = vecs[i].rs2_addr;
      #3;
      chk($sformatf("vec%0d rs1_data", i), rs1_data, vecs[i].e_rs1_data);
      chk($sformatf("vec%0d rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].e_rs1_busy));
      chk($sformatf("vec%0d rs2_data", i), rs2_data, vecs[i].e_rs2_data);
      chk($sformatf("vec%0d rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].e_rs2_busy));
      chk($sformatf("vec%0d busy_count", i), 32'(busy_count), 32'(vecs[i].e_bc));
    end

    // Saturate the scoreboard: every register except x0 claimed.
    for (int r = 1; r < 32; r++) begin
      next_cycle();
      idle();
      claim_en = 1'b1; claim_addr = 5'(r);
    end
    next_cycle();
    idle();
    rs1_addr = 5'd31; rs2_addr = 5'd1;
    #3;
    chk("full busy_count", 32'(busy_count), 32'd31);
    chk("full rs1_busy x31", 32'(rs1_busy), 32'h1);
    chk("full rs2_busy x1", 32'(rs2_busy), 32'h1);

    flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd2;
    next_cycle();
    idle();
    rs1_addr = 5'd2; rs2_addr = 5'd31;
    #3;
    chk("flush busy_count", 32'(busy_count), 32'h0);
    chk("flush rs1_busy x2", 32'(rs1_busy), 32'h0);
    chk("flush rs2_busy x31", 32'(rs2_busy), 32'h0);

    // Asynchronous reset pulse between edges.
    next_cycle();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1234;
    claim_en = 1'b1; claim_addr = 5'd12;
    next_cycle();
    idle();
    rs1_addr = 5'd10; rs2_addr = 5'd12;
    #1;
    chk("pre-rst rs1_data x10", rs1_data, 32'h1234);
    chk("pre-rst rs2_busy x12", 32'(rs2_busy), 32'h1);
    chk("pre-rst busy_count", 32'(busy_count), 32'd1);
    rst = 1'b1;
    #1;
    chk("in-rst rs1_data", rs1_data, 32'h0);
    chk("in-rst rs2_busy", 32'(rs2_busy), 32'h0);
    chk("in-rst busy_count", 32'(busy_count), 32'h0);
    rst = 1'b0;
    #1;
    chk("post-rst rs1_data x10", rs1_data, 32'h0);
    chk("post-rst rs2_busy x12", 32'(rs2_busy), 32'h0);

    // Reset held across an edge blocks writes and claims.
    next_cycle();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'd77;
    claim_en = 1'b1; claim_addr = 5'd13;
    next_cycle();
    rst = 1'b0;
    idle();
    rs1_addr = 5'd11; rs2_addr = 5'd13;
    #3;
    chk("rst-edge rs1_data x11", rs1_data, 32'h0);
    chk("rst-edge rs2_busy x13", 32'(rs2_busy), 32'h0);
    chk("rst-edge busy_count", 32'(busy_count), 32'h0);
    claim_en = 1'b1; claim_addr = 5'd13;
    next_cycle();
    idle();
    #3;
    chk("after-rst claim rs2_busy x13", 32'(rs2_busy), 32'h1);
    chk("after-rst claim busy_count", 32'(busy_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
